// File: rtl/axis_arb_mux.sv
// axis_arb_mux: N:1 AXI-Stream packet arbiter/mux. A granted input owns the
// output from its first beat to its tlast beat. The output is fully registered
// through an output register backed by one skid register.
module axis_arb_mux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 137,
    parameter int NUM_PORTS  = 2,
    parameter int ARB_MODE   = 0,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    output logic [SEL_WIDTH-1:0]            m_axis_tid,
    input  logic                            m_axis_tready,
    output logic                            busy
);

    typedef struct packed {
        logic [SEL_WIDTH-1:0]  tid;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [KEEP_WIDTH-1:0] keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t               r_state, w_state_nxt;
    logic [SEL_WIDTH-1:0] r_grant, r_rr_ptr, w_arb_idx;
    logic                 w_arb_vld, w_gnt_vld, w_acc, w_drain;
    int                   w_base;
    beat_t                w_in, r_out, r_skid;
    logic                 r_out_vld, r_skid_vld;

    // Pick the winning port: first valid port scanning upward from the base
    // (base is 0 for fixed priority, the round-robin pointer otherwise).
    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        w_base    = (ARB_MODE == 1) ? int'(r_rr_ptr) : 0;
        for (int k = NUM_PORTS-1; k >= 0; k--) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if ((j == (w_base + k) % NUM_PORTS) && s_axis_tvalid[j]) begin
                    w_arb_vld = 1'b1;
                    w_arb_idx = SEL_WIDTH'(j);
                end
            end
        end
    end

    // Select the granted port's beat and valid.
    always_comb begin
        w_in      = '0;
        w_gnt_vld = 1'b0;
        w_in.tid  = r_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant == SEL_WIDTH'(i)) begin
                w_in.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_in.keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_in.user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                w_in.last = s_axis_tlast[i];
                w_gnt_vld = s_axis_tvalid[i];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: grant on any valid, release after the tlast transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_vld) w_state_nxt = S_GRANT;
            S_GRANT: if (w_acc && w_in.last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: only the granted port sees ready, and only while skid is free.
    always_comb begin
        s_axis_tready = '0;
        w_acc         = 1'b0;
        busy          = (r_state == S_GRANT);
        if (r_state == S_GRANT) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_grant == SEL_WIDTH'(i)) s_axis_tready[i] = ~r_skid_vld;
            end
            w_acc = w_gnt_vld & ~r_skid_vld;
        end
    end

    // Latch the arbitration winner and advance the round-robin pointer at packet end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == S_IDLE && w_arb_vld) r_grant <= w_arb_idx;
            if (w_acc && w_in.last)
                r_rr_ptr <= (r_grant == SEL_WIDTH'(NUM_PORTS-1)) ? '0 : r_grant + 1'b1;
        end
    end

    assign w_drain = r_out_vld & m_axis_tready;

    // Output register + skid: refill output from skid first, else straight from
    // the input; park the beat in skid only when the output is stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_drain || !r_out_vld) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                if (w_acc) r_out <= w_in;
                r_out_vld <= w_acc;
            end
        end else if (w_acc) begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
        end
    end

    assign m_axis_tdata  = r_out.data;
    assign m_axis_tkeep  = r_out.keep;
    assign m_axis_tuser  = r_out.user;
    assign m_axis_tlast  = r_out.last;
    assign m_axis_tid    = r_out.tid;
    assign m_axis_tvalid = r_out_vld;

endmodule

// File: tb/tb_axis_arb_mux.sv
// tb_axis_arb_mux: two 4-port instances (fixed priority and round-robin) driven
// by directed sequences and randomized packet sets; a packet-level arbitration
// model predicts the exact output beat stream.
module tb_axis_arb_mux;
    localparam int DW = 32, KW = 4, UW = 8, NP = 4, SW = 3, MAXP = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NP*DW-1:0] s_tdata [2];
    logic [NP*KW-1:0] s_tkeep [2];
    logic [NP*UW-1:0] s_tuser [2];
    logic [NP-1:0]    s_tlast [2], s_tvalid [2], s_tready [2];
    logic [DW-1:0]    m_tdata [2];
    logic [KW-1:0]    m_tkeep [2];
    logic [UW-1:0]    m_tuser [2];
    logic [SW-1:0]    m_tid [2];
    logic             m_tlast [2], m_tvalid [2], m_tready [2], busy [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_arb_mux #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                       .NUM_PORTS(NP), .ARB_MODE(g), .SEL_WIDTH(SW)) u_dut (
            .CLK(clk), .RST(rst),
            .s_axis_tdata(s_tdata[g]), .s_axis_tkeep(s_tkeep[g]), .s_axis_tuser(s_tuser[g]),
            .s_axis_tlast(s_tlast[g]), .s_axis_tvalid(s_tvalid[g]), .s_axis_tready(s_tready[g]),
            .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]), .m_axis_tuser(m_tuser[g]),
            .m_axis_tlast(m_tlast[g]), .m_axis_tvalid(m_tvalid[g]), .m_axis_tid(m_tid[g]),
            .m_axis_tready(m_tready[g]), .busy(busy[g])
        );
    end

    int n_chk = 0, n_fail = 0;
    int npk [NP];
    int plen [NP][MAXP];
    int st [NP];
    int ck [NP];
    int cb [NP];
    int cyc;
    logic [47:0] expq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat content is a pure function of (port, packet, beat) so the model can rebuild it.
    function automatic logic [47:0] beat_val(input int p, input int k, input int b, input int len);
        logic [31:0] dat;
        logic [3:0]  kp;
        logic [7:0]  us;
        dat = {4'(p), 12'(k), 8'(b), 8'(len)};
        kp  = 4'(p + k + b) ^ 4'hA;
        us  = 8'(k * 37 + b * 11 + p);
        return {3'(p), (b == len - 1), us, kp, dat};
    endfunction

    function automatic logic [47:0] out_word(input int d);
        return {m_tid[d], m_tlast[d], m_tuser[d], m_tkeep[d], m_tdata[d]};
    endfunction

    task automatic clr_inputs();
        for (int d = 0; d < 2; d++) begin
            s_tdata[d] = '0; s_tkeep[d] = '0; s_tuser[d] = '0;
            s_tlast[d] = '0; s_tvalid[d] = '0; m_tready[d] = 1'b1;
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clr_pkts();
        for (int p = 0; p < NP; p++) begin
            npk[p] = 0; st[p] = 0;
        end
    endtask

    task automatic put(input int d, input int p, input bit v, input logic [31:0] dat, input bit last);
        s_tvalid[d][p] = v;
        s_tlast[d][p]  = last;
        s_tdata[d][p*DW +: DW] = dat;
        s_tkeep[d][p*KW +: KW] = 4'hF;
        s_tuser[d][p*UW +: UW] = 8'h00;
    endtask

    task automatic drive(input int d, input int p, input bit on);
        logic [47:0] w;
        int k;
        k = (ck[p] < npk[p]) ? ck[p] : 0;
        w = beat_val(p, k, cb[p], plen[p][k]);
        s_tvalid[d][p] = on;
        s_tdata[d][p*DW +: DW] = w[31:0];
        s_tkeep[d][p*KW +: KW] = w[35:32];
        s_tuser[d][p*UW +: UW] = w[43:36];
        s_tlast[d][p] = w[44];
    endtask

    task automatic push_pkt(input int p, input int k);
        for (int b = 0; b < plen[p][k]; b++) expq.push_back(beat_val(p, k, b, plen[p][k]));
    endtask

    // Packet-level reference: every port holding packets is valid whenever the
    // arbiter looks, so the order follows directly from the priority rule.
    task automatic build_exp(input int mode);
        int rem [NP];
        int kk [NP];
        int ptr, g;
        bit done;
        expq.delete();
        ptr = 0;
        done = 1'b0;
        for (int p = 0; p < NP; p++) begin
            rem[p] = npk[p]; kk[p] = 0;
        end
        while (!done) begin
            g = -1;
            for (int k = 0; k < NP; k++)
                if (g < 0 && rem[(ptr + k) % NP] > 0) g = (ptr + k) % NP;
            if (g < 0) done = 1'b1;
            else begin
                push_pkt(g, kk[g]);
                rem[g]--; kk[g]++;
                if (mode == 1) ptr = (g + 1) % NP;
            end
        end
    endtask

    task automatic run(input int d, input int mode, input int stallpct, input bit use_model, input int budget);
        logic [47:0]   cur, prev;
        logic [NP-1:0] acc;
        bit            held, on;
        int            bad_rdy, left, extra;
        if (use_model) build_exp(mode);
        cyc = 0; held = 1'b0; bad_rdy = 0; cur = '0; prev = '0;
        for (int p = 0; p < NP; p++) begin
            ck[p] = 0; cb[p] = 0;
            drive(d, p, (npk[p] > 0) && (st[p] == 0));
        end
        m_tready[d] = 1'b1;
        while (expq.size() > 0 && cyc < budget) begin
            @(negedge clk);
            acc = s_tvalid[d] & s_tready[d];
            if (!$onehot0(s_tready[d])) bad_rdy++;
            if (m_tvalid[d]) begin
                cur = out_word(d);
                if (held) chk("hold", cur, prev);
                if (m_tready[d]) chk("beat", cur, expq.pop_front());
            end
            held = m_tvalid[d] & ~m_tready[d];
            prev = cur;
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if (cb[p] == plen[p][ck[p]] - 1) begin ck[p]++; cb[p] = 0; end
                    else cb[p]++;
                end
                if (!s_tvalid[d][p] || acc[p]) begin
                    on = (ck[p] < npk[p]) && (cyc >= st[p]) &&
                         (cb[p] == 0 || $urandom_range(0, 3) != 0);
                    drive(d, p, on);
                end
            end
            m_tready[d] = ($urandom_range(0, 99) >= stallpct);
        end
        chk("timeout_left", expq.size(), 0);
        left = 0;
        for (int p = 0; p < NP; p++) left += npk[p] - ck[p];
        chk("src_left", left, 0);
        m_tready[d] = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_tvalid[d]) extra++;
        end
        chk("extra_beats", extra, 0);
        chk("rdy_onehot", bad_rdy, 0);
        s_tvalid[d] = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0]  bp_rdy;
        logic [47:0] cur, prev;
        bit          a, held;
        int          nb, nd;

        // Reset state
        rst = 1'b1;
        clr_inputs();
        repeat (2) @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk("rst_state", {m_tvalid[d], m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d],
                              m_tid[d], busy[d], s_tready[d]}, 0);
        rst = 1'b0;

        // Single 3-beat packet on port 0: 1-cycle arbitration, 1-cycle beat latency
        put(0, 0, 1, 32'hA1, 0);
        @(posedge clk); #1;
        chk("p3_arb", {busy[0], s_tready[0], m_tvalid[0]}, {1'b1, 4'b0001, 1'b0});
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            chk("p3_out", {m_tvalid[0], m_tdata[0], m_tlast[0], m_tid[0]},
                {1'b1, 32'hA1 + 32'(b), (b == 2), 3'd0});
            chk("p3_busy", busy[0], (b < 2));
            if (b < 2) put(0, 0, 1, 32'hA2 + 32'(b), (b == 1));
            else       put(0, 0, 0, 32'h0, 0);
        end
        @(posedge clk); #1;
        chk("p3_idle", m_tvalid[0], 0);

        // Backpressure: 3 stall cycles mid-packet on a 4-beat counter packet
        reset_all();
        bp_rdy = 10'b0011000110;
        nb = 0; nd = 0; held = 1'b0; cur = '0; prev = '0;
        put(0, 0, 1, 32'h10, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_rdy", s_tready[0][0], bp_rdy[c]);
            a = s_tvalid[0][0] & s_tready[0][0];
            if (m_tvalid[0]) begin
                cur = out_word(0);
                if (held) chk("bp_hold", cur, prev);
                if (m_tready[0]) begin
                    chk("bp_beat", {m_tdata[0], m_tlast[0]}, {32'h10 + 32'(nd), (nd == 3)});
                    nd++;
                end
            end
            held = m_tvalid[0] & ~m_tready[0];
            prev = cur;
            @(posedge clk); #1;
            if (a) nb++;
            put(0, 0, (nb < 4), 32'h10 + 32'(nb), (nb == 3));
            m_tready[0] = !(c >= 1 && c <= 3);
        end
        chk("bp_cnt", nd, 4);

        // Fixed priority: port 0 keeps winning, port 1 waits until port 0 runs dry
        reset_all();
        clr_pkts();
        npk[0] = 3; npk[1] = 3;
        for (int k = 0; k < 3; k++) begin plen[0][k] = 2; plen[1][k] = 2; end
        run(0, 0, 0, 1, 500);

        // Round-robin with single-beat packets: tid 0,1,2,3,0,1,2,3
        reset_all();
        clr_pkts();
        for (int p = 0; p < NP; p++) begin
            npk[p] = 2; plen[p][0] = 1; plen[p][1] = 1;
        end
        run(1, 1, 0, 1, 500);

        // Port 1 mid-packet when higher-priority port 0 shows up
        reset_all();
        clr_pkts();
        npk[1] = 1; plen[1][0] = 5;
        npk[0] = 1; plen[0][0] = 2; st[0] = 3;
        expq.delete();
        push_pkt(1, 0);
        push_pkt(0, 0);
        run(0, 0, 0, 0, 500);

        // Asynchronous reset pulse while beat 2 of 4 sits in the skid
        reset_all();
        put(0, 0, 1, 32'h20, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tready[0] = 1'b0;
        put(0, 0, 1, 32'h21, 0);
        @(posedge clk); #1;
        put(0, 0, 1, 32'h22, 0);
        chk("rs_full", {s_tready[0], m_tvalid[0], m_tdata[0]}, {4'b0000, 1'b1, 32'h20});
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rs_zero", {m_tvalid[0], m_tdata[0], m_tkeep[0], m_tuser[0], m_tlast[0],
                        m_tid[0], busy[0], s_tready[0]}, 0);
        #1 rst = 1'b0;
        clr_inputs();
        clr_pkts();
        npk[0] = 2; plen[0][0] = 3; plen[0][1] = 2;
        npk[2] = 1; plen[2][0] = 4;
        run(0, 0, 20, 1, 500);

        // Randomized packet sets with gaps and random downstream stalls
        for (int it = 0; it < 8; it++) begin
            reset_all();
            clr_pkts();
            for (int p = 0; p < NP; p++) begin
                npk[p] = $urandom_range(0, 5);
                for (int k = 0; k < MAXP; k++) plen[p][k] = $urandom_range(1, 5);
            end
            run(it % 2, it % 2, 30, 1, 3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_arb_mux.md
Name: axis_arb_mux
Overview:
- Parametrised N-input to 1-output AXI-Stream arbiter/mux for the SmartNIC DSM datapath.
- Merges streams such as the network RX path and the protocol-processor request path onto one downstream master.
- Arbitration is per packet: a granted input owns the output from first beat until its tlast beat.
- Full tready/tvalid backpressure on every port.
- Two-entry skid buffer on the output, so the output is fully registered.

Parameters:
- DATA_WIDTH, 512, tdata width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 137, tuser width.
- NUM_PORTS, 2, number of slave inputs (2..8).
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin.
- SEL_WIDTH, 3, width of m_axis_tid port-index output.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed input data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  packed byte enables.
- s_axis_tuser  in  NUM_PORTS*USER_WIDTH  packed sideband.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready; combinational from grant and skid state.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tuser  out  USER_WIDTH  output sideband.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tid  out  SEL_WIDTH  index of the source port for the current beat.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while a packet is in flight (grant held).

Behaviour:
- Reset (RST high, asynchronous): all outputs 0, skid empty, state IDLE, round-robin pointer 0. RST asserted mid-packet drops the packet; no partial-packet recovery.
- State machine IDLE / GRANT:
  - IDLE: arbitrate over s_axis_tvalid. The chosen port index is registered, state moves to GRANT, and busy = 1 from the next cycle. No beat is accepted in the arbitration cycle, so first-beat arbitration latency is 1 cycle.
  - GRANT: s_axis_tready[g] = ~skid_full; all other readies are 0.
  - A beat transfers on s_axis_tvalid[g] & s_axis_tready[g].
  - Transfer with tlast = 1: return to IDLE next cycle; busy deasserts.
- Fixed priority: the lowest-index valid port wins.
- Round-robin: search starts at pointer p. After a packet ends, p = (g+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- Skid buffer:
  - Structure: an output register plus one skid register.
  - Normal case: an accepted beat loads the output register when it is empty or being drained that cycle; otherwise it loads the skid register.
  - On drain (m_axis_tvalid & m_axis_tready), skid moves to output.
  - Input-to-output latency is 1 cycle when unstalled.
  - Throughput is 1 beat/cycle sustained.
  - skid_full = skid register occupied. s_axis_tready drops the cycle after skid fills.
- Data integrity: m_axis_tdata, tkeep, tuser, tlast, and tid are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Simultaneous events:
  - A tlast transfer and a new valid on another port in the same cycle: the new port is arbitrated in the following IDLE cycle.
  - A valid on the currently granted port is ignored when the grant is not held.
  - A drain and a new accept in the same cycle with skid empty: direct output-register reload, no bubble.
- Inputs that deassert tvalid mid-packet stall the grant; the grant is not revoked (no timeout).
- Zero-length packets do not exist. A single-beat packet with tlast = 1 is legal.
- Packets are never interleaved on the output; beats of one packet are contiguous.

Test Plan:
- Single port 0 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3; tlast on beat 3) with m_axis_tready = 1:
  - output beats in order 1 cycle after acceptance;
  - m_axis_tid = 0;
  - busy high for 3 cycles after grant.
- ARB_MODE = 0, ports 0 and 1 both continuously valid with 2-beat packets:
  - only port 0 packets are output;
  - port 1 is starved, as specified.
- ARB_MODE = 1, NUM_PORTS = 4, all ports valid with 1-beat packets:
  - tid sequence is 0, 1, 2, 3, 0 (pointer wrap checked).
- Backpressure: m_axis_tready is 0 for 3 cycles mid-packet:
  - s_axis_tready falls after skid fills;
  - no beat is lost or duplicated;
  - the output is held stable;
  - 4-beat packet integrity is checked via a tdata counter.
- Port 1 is mid-packet when port 0 asserts valid:
  - port 1 completes to tlast first, then port 0 is granted;
  - no interleaving.
- RST pulsed high for 1 cycle asynchronously while beat 2 of 4 is in the skid:
  - all outputs 0 immediately;
  - state IDLE;
  - next packet passes cleanly.
